demux3_reg: RTL and testbench

DEMUX3_REG -- requirements
Module: demux3_reg

---
 rtl/mux_sel_pkg.sv | 24 ++
 rtl/demux3_reg_if.sv | 21 ++
 rtl/demux3_slot.sv | 52 +++++
 rtl/demux3_reg.sv | 112 +++++++++++
 tb/tb_demux3_reg.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_pkg.sv
// Shared selector codes and slot state type
// for the demux3_reg block and its siblings.
package mux_sel_pkg;

  localparam logic [2:0] SEL_CH0 = 3'b000;
  localparam logic [2:0] SEL_CH1 = 3'b001;
  localparam logic [2:0] SEL_CH2 = 3'b010;

  localparam int N_CH = 3;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  function automatic logic sel_is_legal(
    input logic [2:0] sel
  );
    return (sel == SEL_CH0) ||
           (sel == SEL_CH1) ||
           (sel == SEL_CH2);
  endfunction

endpackage

// File: rtl/demux3_reg_if.sv
// Valid/ready/data channel bundle used on
// each demux3_reg output slot.
interface demux3_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/demux3_slot.sv
// One-entry output slot: EMPTY/FULL state
// plus a held word that resets to zero.
module demux3_slot
  import mux_sel_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] word,
  demux3_reg_if.master      ch
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (write) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (!write && ch.ready)
          w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (write) begin
      r_data <= word;
    end
  end

  assign ch.valid = (r_state == S_FULL);
  assign ch.data  = r_data;

endmodule

// File: rtl/demux3_reg.sv
// Registered 1-to-3 demultiplexer with one-entry
// slot per channel and illegal-selector counter.
module demux3_reg
  import mux_sel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        selector,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid_0,
  output logic              out_valid_1,
  output logic              out_valid_2,
  input  logic              out_ready_0,
  input  logic              out_ready_1,
  input  logic              out_ready_2,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [CNT_W-1:0]  illegal_cnt
);

  logic [N_CH-1:0] w_sel_oh;
  logic            w_illegal;
  logic [N_CH-1:0] w_valid;
  logic [N_CH-1:0] w_ready;
  logic [N_CH-1:0] w_wr;
  logic            w_xfer;
  logic [CNT_W-1:0] r_cnt;

  // Illegal codes fall through to channel 0.
  always_comb begin
    w_sel_oh  = 3'b001;
    w_illegal = 1'b0;
    unique case (1'b1)
      (selector == SEL_CH0): w_sel_oh = 3'b001;
      (selector == SEL_CH1): w_sel_oh = 3'b010;
      (selector == SEL_CH2): w_sel_oh = 3'b100;
      default: begin
        w_sel_oh  = 3'b001;
        w_illegal = !sel_is_legal(selector);
      end
    endcase
  end

  assign w_ready  = {out_ready_2,
                     out_ready_1,
                     out_ready_0};
  assign in_ready = |(w_sel_oh &
                      (~w_valid | w_ready));
  assign w_xfer   = in_valid & in_ready;
  assign w_wr     = w_sel_oh & {N_CH{w_xfer}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_xfer && w_illegal &&
                 (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign illegal_cnt = r_cnt;

  demux3_reg_if #(.DATA_W(DATA_W)) u_ch0_if ();
  demux3_reg_if #(.DATA_W(DATA_W)) u_ch1_if ();
  demux3_reg_if #(.DATA_W(DATA_W)) u_ch2_if ();

  assign u_ch0_if.ready = out_ready_0;
  assign u_ch1_if.ready = out_ready_1;
  assign u_ch2_if.ready = out_ready_2;

  demux3_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk   (clk),
    .reset (reset),
    .write (w_wr[0]),
    .word  (data_in),
    .ch    (u_ch0_if.master)
  );

  demux3_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk   (clk),
    .reset (reset),
    .write (w_wr[1]),
    .word  (data_in),
    .ch    (u_ch1_if.master)
  );

  demux3_slot #(.DATA_W(DATA_W)) u_slot2 (
    .clk   (clk),
    .reset (reset),
    .write (w_wr[2]),
    .word  (data_in),
    .ch    (u_ch2_if.master)
  );

  assign w_valid = {u_ch2_if.valid,
                    u_ch1_if.valid,
                    u_ch0_if.valid};

  assign out_valid_0 = u_ch0_if.valid;
  assign out_valid_1 = u_ch1_if.valid;
  assign out_valid_2 = u_ch2_if.valid;
  assign data_out_0  = u_ch0_if.data;
  assign data_out_1  = u_ch1_if.data;
  assign data_out_2  = u_ch2_if.data;

endmodule

// File: tb/tb_demux3_reg.sv
// Directed self-checking bench for demux3_reg
// (DATA_W=32, CNT_W=2 to reach saturation).
module tb_demux3_reg;

  logic        clk;
  logic        reset;
  logic [2:0]  sel;
  logic        r0, r1, r2;
  logic        ov0, ov1, ov2;
  logic [31:0] d0, d1, d2;
  logic [1:0]  cnt;
  int          total;
  int          bad;

  demux3_reg_if #(.DATA_W(32)) u_in ();

  demux3_reg #(.DATA_W(32), .CNT_W(2)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (u_in.valid),
    .in_ready    (u_in.ready),
    .selector    (sel),
    .data_in     (u_in.data),
    .out_valid_0 (ov0),
    .out_valid_1 (ov1),
    .out_valid_2 (ov2),
    .out_ready_0 (r0),
    .out_ready_1 (r1),
    .out_ready_2 (r2),
    .data_out_0  (d0),
    .data_out_1  (d1),
    .data_out_2  (d2),
    .illegal_cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #2;
    total++;
    if ({ov2, ov1, ov0} !== 3'b000) begin
      bad++;
      $display("FAIL rst_valid got=%b exp=000", {ov2, ov1, ov0});
    end
    total++;
    if ({d0, d1, d2} !== 96'h0) begin
      bad++;
      $display("FAIL rst_data got=%h %h %h exp=0", d0, d1, d2);
    end
    total++;
    if (cnt !== 2'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d exp=0", cnt);
    end
    total++;
    if (u_in.ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=1", u_in.ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_routing;
    @(negedge clk);
    sel = 3'b001;
    u_in.data = 32'hCAFE0001;
    u_in.valid = 1'b1;
    #1;
    total++;
    if (u_in.ready !== 1'b1) begin
      bad++;
      $display("FAIL route_rdy got=%b exp=1", u_in.ready);
    end
    @(negedge clk);
    u_in.valid = 1'b0;
    total++;
    if ({ov2, ov1, ov0} !== 3'b010) begin
      bad++;
      $display("FAIL route_valid got=%b exp=010", {ov2, ov1, ov0});
    end
    total++;
    if (d1 !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL route_d1 got=%h exp=cafe0001", d1);
    end
    total++;
    if (d0 !== 32'h0) begin
      bad++;
      $display("FAIL route_d0 got=%h exp=0", d0);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    sel = 3'b010;
    u_in.data = 32'h22;
    u_in.valid = 1'b1;
    @(negedge clk);
    total++;
    if (ov2 !== 1'b1 || d2 !== 32'h22) begin
      bad++;
      $display("FAIL bp_fill got=%b/%h exp=1/22", ov2, d2);
    end
    u_in.data = 32'h33;
    #1;
    total++;
    if (u_in.ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_rdy got=%b exp=0", u_in.ready);
    end
    @(negedge clk);
    total++;
    if (ov2 !== 1'b1 || d2 !== 32'h22) begin
      bad++;
      $display("FAIL bp_hold got=%b/%h exp=1/22", ov2, d2);
    end
    u_in.valid = 1'b0;
    sel = 3'b000;
    #1;
    total++;
    if (u_in.ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_rdy0 got=%b exp=1", u_in.ready);
    end
    sel = 3'b010;
    #1;
    total++;
    if (u_in.ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_rdy2 got=%b exp=0", u_in.ready);
    end
    @(negedge clk);
    total++;
    if (d2 !== 32'h22) begin
      bad++;
      $display("FAIL bp_hold2 got=%h exp=22", d2);
    end
    u_in.valid = 1'b1;
    r2 = 1'b1;
    #1;
    total++;
    if (u_in.ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_rdy got=%b exp=1", u_in.ready);
    end
    @(negedge clk);
    u_in.valid = 1'b0;
    total++;
    if (ov2 !== 1'b1 || d2 !== 32'h33) begin
      bad++;
      $display("FAIL bp_new got=%b/%h exp=1/33", ov2, d2);
    end
    total++;
    if (ov1 !== 1'b1 || d1 !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL bp_ch1 got=%b/%h exp=1/cafe0001", ov1, d1);
    end
    @(negedge clk);
    total++;
    if (ov2 !== 1'b0 || d2 !== 32'h33) begin
      bad++;
      $display("FAIL bp_drain got=%b/%h exp=0/33", ov2, d2);
    end
    r2 = 1'b0;
  endtask

  task automatic test_simul_rw;
    sel = 3'b000;
    u_in.data = 32'hA;
    u_in.valid = 1'b1;
    @(negedge clk);
    total++;
    if (ov0 !== 1'b1 || d0 !== 32'hA) begin
      bad++;
      $display("FAIL rw_fill got=%b/%h exp=1/a", ov0, d0);
    end
    r0 = 1'b1;
    u_in.data = 32'hB;
    #1;
    total++;
    if (u_in.ready !== 1'b1) begin
      bad++;
      $display("FAIL rw_rdy got=%b exp=1", u_in.ready);
    end
    @(negedge clk);
    u_in.valid = 1'b0;
    total++;
    if (ov0 !== 1'b1 || d0 !== 32'hB) begin
      bad++;
      $display("FAIL rw_new got=%b/%h exp=1/b", ov0, d0);
    end
    @(negedge clk);
    total++;
    if (ov0 !== 1'b0) begin
      bad++;
      $display("FAIL rw_drain got=%b exp=0", ov0);
    end
    r0 = 1'b0;
  endtask

  task automatic test_illegal;
    sel = 3'b111;
    u_in.data = 32'h77;
    u_in.valid = 1'b1;
    #1;
    total++;
    if (u_in.ready !== 1'b1) begin
      bad++;
      $display("FAIL ill_rdy got=%b exp=1", u_in.ready);
    end
    @(negedge clk);
    total++;
    if (ov0 !== 1'b1 || d0 !== 32'h77 || cnt !== 2'd1) begin
      bad++;
      $display("FAIL ill_first got=%b/%h/%0d exp=1/77/1", ov0, d0, cnt);
    end
    sel = 3'b101;
    u_in.data = 32'h55;
    #1;
    total++;
    if (u_in.ready !== 1'b0) begin
      bad++;
      $display("FAIL ill_block_rdy got=%b exp=0", u_in.ready);
    end
    @(negedge clk);
    total++;
    if (cnt !== 2'd1 || d0 !== 32'h77) begin
      bad++;
      $display("FAIL ill_noacc got=%0d/%h exp=1/77", cnt, d0);
    end
    r0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_in.data = 32'h80 + i;
      @(negedge clk);
      total++;
      if (cnt !== ((i >= 1) ? 2'd3 : 2'd2) ||
          d0 !== 32'h80 + i) begin
        bad++;
        $display("FAIL ill_sat%0d got=%0d/%h exp=%0d/%h", i, cnt, d0,
                 (i >= 1) ? 3 : 2, 32'h80 + i);
      end
    end
    u_in.valid = 1'b0;
    @(negedge clk);
    total++;
    if (ov0 !== 1'b0 || cnt !== 2'd3) begin
      bad++;
      $display("FAIL ill_end got=%b/%0d exp=0/3", ov0, cnt);
    end
    r0 = 1'b0;
  endtask

  task automatic test_parallel_drain;
    sel = 3'b000;
    u_in.data = 32'h100;
    u_in.valid = 1'b1;
    @(negedge clk);
    sel = 3'b010;
    u_in.data = 32'h102;
    @(negedge clk);
    u_in.valid = 1'b0;
    total++;
    if ({ov2, ov1, ov0} !== 3'b111 || d0 !== 32'h100 ||
        d1 !== 32'hCAFE0001 || d2 !== 32'h102) begin
      bad++;
      $display("FAIL pd_fill got=%b %h %h %h exp=111 100 cafe0001 102",
               {ov2, ov1, ov0}, d0, d1, d2);
    end
    {r2, r1, r0} = 3'b111;
    @(negedge clk);
    total++;
    if ({ov2, ov1, ov0} !== 3'b000) begin
      bad++;
      $display("FAIL pd_drain got=%b exp=000", {ov2, ov1, ov0});
    end
    {r2, r1, r0} = 3'b000;
  endtask

  task automatic test_async_reset;
    sel = 3'b000;
    u_in.data = 32'h200;
    u_in.valid = 1'b1;
    @(negedge clk);
    sel = 3'b001;
    u_in.data = 32'h201;
    @(negedge clk);
    sel = 3'b010;
    u_in.data = 32'h202;
    @(negedge clk);
    total++;
    if ({ov2, ov1, ov0} !== 3'b111 || d1 !== 32'h201) begin
      bad++;
      $display("FAIL ar_fill got=%b/%h exp=111/201", {ov2, ov1, ov0}, d1);
    end
    sel = 3'b001;
    u_in.data = 32'h300;
    r1 = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({ov2, ov1, ov0} !== 3'b000) begin
      bad++;
      $display("FAIL ar_valid got=%b exp=000", {ov2, ov1, ov0});
    end
    total++;
    if ({d0, d1, d2} !== 96'h0 || cnt !== 2'd0) begin
      bad++;
      $display("FAIL ar_data got=%h %h %h cnt=%0d exp=0", d0, d1, d2, cnt);
    end
    @(negedge clk);
    r1 = 1'b0;
    reset = 1'b1;
    sel = 3'b010;
    u_in.data = 32'h400;
    @(negedge clk);
    u_in.valid = 1'b0;
    total++;
    if ({ov2, ov1, ov0} !== 3'b100 || d2 !== 32'h400 ||
        d1 !== 32'h0 || d0 !== 32'h0) begin
      bad++;
      $display("FAIL ar_first got=%b %h %h %h exp=100 0 0 400",
               {ov2, ov1, ov0}, d0, d1, d2);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    sel = 3'b000;
    {r2, r1, r0} = 3'b000;
    u_in.valid = 1'b0;
    u_in.data = 32'h0;
    test_reset();
    test_routing();
    test_backpressure();
    test_simul_rw();
    test_illegal();
    test_parallel_drain();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
